// File: rtl/wb_pkg.sv
// Writeback arbiter package: source enumeration, widths and the result payload.
// Widths come from the codebase-wide defines; fallbacks are provided for
// standalone builds.
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef COMMIT_ID_WIDTH
`define COMMIT_ID_WIDTH 6
`endif

package wb_pkg;

  localparam int unsigned WB_NUM_SRC = 4;
  localparam int unsigned WB_SRC_W   = $clog2(WB_NUM_SRC);
  localparam int unsigned WB_DATA_W  = `REG_DATA_WIDTH;
  localparam int unsigned WB_ADDR_W  = `REG_ADDR_WIDTH;
  localparam int unsigned WB_CID_W   = `COMMIT_ID_WIDTH;

  // Source index order; lower value wins under fixed priority.
  typedef enum logic [WB_SRC_W-1:0] {
    SRC_ALU = 2'd0,
    SRC_LSU = 2'd1,
    SRC_MUL = 2'd2,
    SRC_DIV = 2'd3
  } wb_src_e;

  // One execution-unit result.
  typedef struct packed {
    logic [WB_DATA_W-1:0] wdata;
    logic [WB_ADDR_W-1:0] waddr;
    logic [WB_CID_W-1:0]  commit_id;
  } wb_req_t;

endpackage

// File: rtl/wb_rr_arbiter.sv
// One-hot grant generator for the writeback sources.
// Config macro WB_ARB_RR_EN: defined -> round-robin with a pointer register
// that moves past the last winner; undefined -> fixed priority, index 0 highest.
// Ports:
//   clk, rst_n : clock, async active-low reset (pointer only)
//   req_i      : request vector (already gated by hold/reset)
//   gnt_c      : combinational one-hot grant, subset of req_i
module wb_rr_arbiter
  import wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WB_NUM_SRC-1:0] req_i,
  output logic [WB_NUM_SRC-1:0] gnt_c
);

`ifdef WB_ARB_RR_EN
  logic [WB_SRC_W-1:0] ptr_q;
  logic [WB_SRC_W-1:0] ptr_d;
  logic [WB_SRC_W-1:0] idx;
  logic                found;

  // Scan from the pointer upward, wrapping; the first requester wins.
  always_comb begin
    gnt_c = '0;
    ptr_d = ptr_q;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < WB_NUM_SRC; k++) begin
      idx = WB_SRC_W'((32'(ptr_q) + k) % WB_NUM_SRC);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_c[idx] = 1'b1;
        ptr_d      = WB_SRC_W'((32'(idx) + 1) % WB_NUM_SRC);
      end
    end
  end

  // Pointer register; only moves on an actual grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  logic found;
  logic unused_clk_rst;

  // No state in fixed-priority mode.
  assign unused_clk_rst = clk ^ rst_n;

  // Lowest requesting index wins.
  always_comb begin
    gnt_c = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < WB_NUM_SRC; k++) begin
      if (!found && req_i[WB_SRC_W'(k)]) begin
        found                 = 1'b1;
        gnt_c[WB_SRC_W'(k)]   = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/exu_wb_arb.sv
// Writeback arbiter: picks one completed execution-unit result per cycle and
// registers it onto the register-file write port and the retire strobe.
// Config macro WB_ARB_RR_EN selects round-robin (default: fixed priority).
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   src_valid_i       : per-source result valid
//   src_wdata_i       : per-source data, source k at [k*DATA_W +: DATA_W]
//   src_waddr_i       : per-source destination register, packed likewise
//   src_commit_id_i   : per-source commit id, packed likewise
//   src_ready_o       : combinational one-hot grant (the unit's wb_ready)
//   hold_i            : blocks all grants while high
//   reg_we_o          : register-file write enable (suppressed for x0)
//   reg_waddr_o       : write address
//   reg_wdata_o       : write data
//   commit_valid_o    : retire strobe
//   commit_id_o       : retired commit id
module exu_wb_arb
  import wb_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [WB_NUM_SRC-1:0]          src_valid_i,
  input  logic [WB_NUM_SRC*WB_DATA_W-1:0] src_wdata_i,
  input  logic [WB_NUM_SRC*WB_ADDR_W-1:0] src_waddr_i,
  input  logic [WB_NUM_SRC*WB_CID_W-1:0]  src_commit_id_i,
  output logic [WB_NUM_SRC-1:0]          src_ready_o,
  input  logic                           hold_i,
  output logic                           reg_we_o,
  output logic [WB_ADDR_W-1:0]           reg_waddr_o,
  output logic [WB_DATA_W-1:0]           reg_wdata_o,
  output logic                           commit_valid_o,
  output logic [WB_CID_W-1:0]            commit_id_o
);

  localparam int unsigned NUM_SRC = WB_NUM_SRC;
  localparam int unsigned DATA_W  = WB_DATA_W;
  localparam int unsigned ADDR_W  = WB_ADDR_W;
  localparam int unsigned CID_W   = WB_CID_W;

  logic [NUM_SRC-1:0] req_c;
  logic [NUM_SRC-1:0] gnt_c;
  wb_req_t            src_req [NUM_SRC];
  wb_req_t            sel_c;
  wb_req_t            out_q;
  wb_req_t            out_d;
  logic               we_q;
  logic               we_d;
  logic               cv_q;
  logic               cv_d;

  // Unpack the flat source buses into payload structs.
  always_comb begin
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      src_req[k].wdata     = src_wdata_i[k*DATA_W +: DATA_W];
      src_req[k].waddr     = src_waddr_i[k*ADDR_W +: ADDR_W];
      src_req[k].commit_id = src_commit_id_i[k*CID_W +: CID_W];
    end
  end

  // Hold and reset both suppress every grant.
  assign req_c = src_valid_i & {NUM_SRC{~hold_i & rst_n}};

  wb_rr_arbiter u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req_c),
    .gnt_c (gnt_c)
  );

  assign src_ready_o = gnt_c;

  // One-hot data mux.
  always_comb begin
    sel_c = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (gnt_c[WB_SRC_W'(k)]) sel_c = src_req[k];
    end
  end

  // Output stage: strobes pulse per acceptance, payload holds otherwise.
  always_comb begin
    out_d = out_q;
    we_d  = 1'b0;
    cv_d  = 1'b0;
    if (|gnt_c) begin
      out_d = sel_c;
      cv_d  = 1'b1;
      we_d  = (sel_c.waddr != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      we_q  <= 1'b0;
      cv_q  <= 1'b0;
    end else begin
      out_q <= out_d;
      we_q  <= we_d;
      cv_q  <= cv_d;
    end
  end

  assign reg_we_o       = we_q;
  assign commit_valid_o = cv_q;
  assign reg_waddr_o    = out_q.waddr;
  assign reg_wdata_o    = out_q.wdata;
  assign commit_id_o    = out_q.commit_id;

endmodule

// File: tb/tb_exu_wb_arb.sv
// Self-checking bench for exu_wb_arb: directed scenarios followed by a
// randomized run, all checked against a behavioural arbitration model.
module tb_exu_wb_arb;
  import wb_pkg::*;

  localparam int N  = WB_NUM_SRC;
  localparam int DW = WB_DATA_W;
  localparam int AW = WB_ADDR_W;
  localparam int CW = WB_CID_W;
`ifdef WB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      src_valid_i;
  logic [N*DW-1:0]   src_wdata_i;
  logic [N*AW-1:0]   src_waddr_i;
  logic [N*CW-1:0]   src_commit_id_i;
  logic [N-1:0]      src_ready_o;
  logic              hold_i;
  logic              reg_we_o;
  logic [AW-1:0]     reg_waddr_o;
  logic [DW-1:0]     reg_wdata_o;
  logic              commit_valid_o;
  logic [CW-1:0]     commit_id_o;

  // Source-side view: what each execution unit is currently presenting.
  logic [N-1:0]  v;
  logic [DW-1:0] d [N];
  logic [AW-1:0] a [N];
  logic [CW-1:0] c [N];
  logic          h;
  bit            refill;

  // Reference state.
  int            ptr;
  logic          exp_we, exp_cv;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  logic [CW-1:0] exp_cid;

  int n_cmp  = 0;
  int n_fail = 0;

  exu_wb_arb dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .src_valid_i     (src_valid_i),
    .src_wdata_i     (src_wdata_i),
    .src_waddr_i     (src_waddr_i),
    .src_commit_id_i (src_commit_id_i),
    .src_ready_o     (src_ready_o),
    .hold_i          (hold_i),
    .reg_we_o        (reg_we_o),
    .reg_waddr_o     (reg_waddr_o),
    .reg_wdata_o     (reg_wdata_o),
    .commit_valid_o  (commit_valid_o),
    .commit_id_o     (commit_id_o)
  );

  always #5 clk = ~clk;

  always_comb begin
    src_valid_i     = v;
    hold_i          = h;
    src_wdata_i     = '0;
    src_waddr_i     = '0;
    src_commit_id_i = '0;
    for (int i = 0; i < N; i++) begin
      src_wdata_i[i*DW +: DW]     = d[i];
      src_waddr_i[i*AW +: AW]     = a[i];
      src_commit_id_i[i*CW +: CW] = c[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Winner under the configured policy, or -1 when nothing may be granted.
  function automatic int model_grant();
    int start;
    if (!rst_n || h) return -1;
    start = RR ? ptr : 0;
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic set_src(input int i, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic [CW-1:0] cid);
    v[i] = 1'b1;
    a[i] = addr;
    d[i] = data;
    c[i] = cid;
  endtask

  task automatic new_rand(input int i);
    set_src(i, AW'($urandom_range(0, (1 << AW) - 1)), DW'($urandom), CW'($urandom));
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".we"},   64'(reg_we_o),       64'(exp_we));
    check({tag, ".cv"},   64'(commit_valid_o), 64'(exp_cv));
    check({tag, ".addr"}, 64'(reg_waddr_o),    64'(exp_addr));
    check({tag, ".data"}, 64'(reg_wdata_o),    64'(exp_data));
    check({tag, ".cid"},  64'(commit_id_o),    64'(exp_cid));
  endtask

  task automatic reset_model();
    ptr      = 0;
    exp_we   = 1'b0;
    exp_cv   = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    exp_cid  = '0;
  endtask

  // One clock: inputs were set just after the previous edge; check the grant,
  // advance the model, then check the registered outputs after the edge.
  task automatic cycle(input string tag);
    int g;
    logic [N-1:0] exp_rdy;
    #1;
    g = model_grant();
    exp_rdy = (g >= 0) ? N'(1 << g) : '0;
    check({tag, ".ready"}, 64'(src_ready_o), 64'(exp_rdy));
    if (g >= 0) begin
      exp_cv   = 1'b1;
      exp_we   = (a[g] != '0);
      exp_addr = a[g];
      exp_data = d[g];
      exp_cid  = c[g];
      ptr      = (g + 1) % N;
    end else begin
      exp_cv = 1'b0;
      exp_we = 1'b0;
    end
    @(posedge clk);
    #1;
    if (g >= 0) begin
      if (refill) new_rand(g);
      else        v[g] = 1'b0;
    end
    check_outputs(tag);
  endtask

  initial begin
    rst_n  = 1'b0;
    h      = 1'b0;
    refill = 1'b0;
    reset_model();
    for (int i = 0; i < N; i++) set_src(i, AW'(i + 1), DW'(32'hA000 + i), CW'(i + 8));

    // Reset with everyone valid: no grants, outputs cleared.
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready", 64'(src_ready_o), 64'd0);
    check_outputs("rst");

    // First grant after release goes to index 0.
    rst_n = 1'b1;
    cycle("first");
    check("first.we_const", 64'(reg_we_o), 64'd1);
    check("first.addr_const", 64'(reg_waddr_o), 64'd1);
    v = '0;
    cycle("idle");

    // Single MUL result.
    set_src(int'(SRC_MUL), AW'(5), 32'h1234_5678, CW'(2));
    #1;
    check("mul.ready_const", 64'(src_ready_o), 64'b0100);
    cycle("mul");
    check("mul.data_const", 64'(reg_wdata_o), 64'h1234_5678);
    check("mul.cid_const", 64'(commit_id_o), 64'd2);

    // DIV alone, which also brings the round-robin pointer back to 0.
    set_src(int'(SRC_DIV), AW'(9), DW'(32'hD1D1), CW'(3));
    cycle("div");

    // All four valid and continuously re-presented.
    refill = 1'b1;
    for (int i = 0; i < N; i++) new_rand(i);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("all4.ready_const", 64'(src_ready_o), RR ? 64'(1 << i) : 64'd1);
      cycle("all4");
    end
    refill = 1'b0;
    v = '0;
    cycle("drain");

    // x0 destination retires without writing.
    set_src(int'(SRC_LSU), AW'(0), DW'(32'hBEEF), CW'(5));
    cycle("x0");
    check("x0.we_const", 64'(reg_we_o), 64'd0);
    check("x0.cv_const", 64'(commit_valid_o), 64'd1);

    // Back-to-back ALU and MUL.
    set_src(int'(SRC_ALU), AW'(7), DW'(32'h7777), CW'(6));
    set_src(int'(SRC_MUL), AW'(12), DW'(32'hCCCC), CW'(7));
    cycle("b2b0");
    cycle("b2b1");

    // Hold for three cycles with MUL pending, then release.
    h = 1'b1;
    set_src(int'(SRC_MUL), AW'(3), DW'(32'h3333), CW'(1));
    for (int i = 0; i < 3; i++) cycle("hold");
    h = 1'b0;
    cycle("unhold");
    check("unhold.addr_const", 64'(reg_waddr_o), 64'd3);

    // Reset asserted mid-operation.
    for (int i = 0; i < N; i++) new_rand(i);
    cycle("pre_rst");
    rst_n = 1'b0;
    reset_model();
    #1;
    check("midrst.ready", 64'(src_ready_o), 64'd0);
    check_outputs("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle("post_rst");

    // Randomized traffic: sources hold until granted, may drop valid.
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && ($urandom_range(0, 1) == 0)) new_rand(i);
        else if (v[i] && ($urandom_range(0, 15) == 0)) v[i] = 1'b0;
      end
      h = ($urandom_range(0, 7) == 0);
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
